icache_dm: RTL and testbench

ICACHE_DM -- requirements
Module: icache_dm

---
 rtl/icache_dm.sv | 66 ++++++
 tb/tb_icache_dm.sv | 138 +++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache, 32-byte lines, one line fill at a time
module icache_dm #(
  parameter int NUM_SETS_LOG2 = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic [31:0]  mem_address,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);
  localparam int SETS = 1 << NUM_SETS_LOG2;
  localparam int TW = 27 - NUM_SETS_LOG2;
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state_q;
  logic [SETS-1:0] valid_q;
  logic [TW-1:0] tag_q [SETS];
  logic [255:0] line_q [SETS];
  logic [TW-1:0] ltag_q;
  logic [NUM_SETS_LOG2-1:0] lidx_q;
  logic pmem_read_q;
  logic [NUM_SETS_LOG2-1:0] idx;
  logic [TW-1:0] tag;
  logic hit;
  logic unused_ok;
  assign unused_ok = ^mem_address[1:0];
  assign idx = mem_address[4+NUM_SETS_LOG2:5];
  assign tag = mem_address[31:5+NUM_SETS_LOG2];
  assign hit = valid_q[idx] && tag_q[idx] == tag;
  assign mem_resp = state_q == IDLE && mem_read && hit;
  assign mem_rdata = line_q[idx][{mem_address[4:2], 5'b0} +: 32];
  assign pmem_read = pmem_read_q;
  assign pmem_address = {ltag_q, lidx_q, 5'b0};
  // Miss latches the line address and starts a fill; the fill completes on pmem_resp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      ltag_q <= '0;
      lidx_q <= '0;
      pmem_read_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (mem_read && !hit) begin
        state_q <= FETCH;
        ltag_q <= tag;
        lidx_q <= idx;
        pmem_read_q <= 1'b1;
      end
    end else if (pmem_resp) begin
      state_q <= IDLE;
      valid_q[lidx_q] <= 1'b1;
      pmem_read_q <= 1'b0;
    end
  end
  // Line and tag storage needs no reset; a reset in the fill cycle suppresses the write
  always_ff @(posedge clk) begin
    if (!rst && state_q == FETCH && pmem_resp) begin
      line_q[lidx_q] <= pmem_rdata;
      tag_q[lidx_q] <= ltag_q;
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed fetch vectors with a response scoreboard and a behavioural backing memory
module tb_icache_dm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_read = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_rdata;
  logic mem_resp;
  logic pmem_read;
  logic [31:0] pmem_address;
  logic [255:0] pmem_rdata = '0;
  logic pmem_resp = 1'b0;
  int vecs = 0;
  int errs = 0;
  logic [31:0] exp_q [$];

  icache_dm dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_address(mem_address),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_read(pmem_read),
    .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[31:2], 2'b00};
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = word_of({a[31:5], w[2:0], 2'b00});
    return l;
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_resp === 1'b1) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_resp: got resp for %h, expected none", mem_address);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (mem_rdata !== e) begin
          errs++;
          $display("FAIL rdata @%h: got %h, expected %h", mem_address, mem_rdata, e);
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input bit miss, input int lat, input bit chg, input logic [31:0] a2);
    mem_read = 1'b1;
    mem_address = a;
    if (miss) begin
      @(negedge clk);
      chk("miss_resp", {31'b0, mem_resp}, 32'd0);
      chk("miss_pread", {31'b0, pmem_read}, 32'd0);
      @(posedge clk); #1;
      if (chg) mem_address = a2;
      for (int i = 0; i < lat; i++) begin
        if (i == lat - 1) begin
          pmem_resp = 1'b1;
          pmem_rdata = line_of(a);
        end
        @(negedge clk);
        chk("fill_pread", {31'b0, pmem_read}, 32'd1);
        chk("fill_paddr", pmem_address, {a[31:5], 5'b0});
        chk("fill_resp", {31'b0, mem_resp}, 32'd0);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
      end
      mem_address = a;
    end
    exp_q.push_back(word_of(a));
    @(negedge clk);
    chk("hit_resp", {31'b0, mem_resp}, 32'd1);
    chk("hit_pread", {31'b0, pmem_read}, 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_resp", {31'b0, mem_resp}, 32'd0);
    chk("rst_pread", {31'b0, pmem_read}, 32'd0);
    chk("rst_paddr", pmem_address, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    fetch(32'h60, 1, 3, 0, 0);
    for (int i = 0; i < 8; i++) fetch(32'h60 + 32'(i * 4), 0, 0, 0, 0);
    fetch(32'h6B, 0, 0, 0, 0);
    fetch(32'h260, 1, 2, 0, 0);
    fetch(32'h260, 0, 0, 0, 0);
    fetch(32'h60, 1, 1, 0, 0);
    fetch(32'h100, 1, 4, 1, 32'h400);
    fetch(32'h400, 1, 2, 0, 0);
    fetch(32'h104, 0, 0, 0, 0);
    fetch(32'h7C, 0, 0, 0, 0);
    mem_read = 1'b1;
    mem_address = 32'h300;
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk);
    chk("pre_rst_pread", {31'b0, pmem_read}, 32'd1);
    @(posedge clk); #1;
    pmem_resp = 1'b1;
    pmem_rdata = line_of(32'h300);
    rst = 1'b1;
    #1;
    chk("rst_mid_pread", {31'b0, pmem_read}, 32'd0);
    chk("rst_mid_paddr", pmem_address, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pmem_resp = 1'b0;
    fetch(32'h300, 1, 2, 0, 0);
    fetch(32'h60, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      mem_address = 32'h60 + 32'(i * 36);
      @(negedge clk);
      chk("idle_resp", {31'b0, mem_resp}, 32'd0);
      chk("idle_pread", {31'b0, pmem_read}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pending_resps", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
